pergate_mul_arbiter: RTL and testbench

- Round-robin arbiter that shares one field_multiplier among n_req requesters, such as per-gate gatefn evaluators and chi/beta update logic in a sumcheck layer.
- Each requester presents an operand pair. The arbiter grants one requester at a time, sequences the multiplier's en/ready handshake, and returns the product with a one-cycle ack.
- It sits between the per-gate compute blocks and a single multiplier instance, trading throughput for multiplier area.

---
 rtl/pergate_mul_arbiter.sv | 107 ++++++++++
 tb/tb_pergate_mul_arbiter.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pergate_mul_arbiter.sv
// Round-robin arbiter sharing one field multiplier among NReq requesters.
// Captures the winner's operands, drives the en/ready handshake and returns the product with an ack.
module pergate_mul_arbiter #(
  parameter int unsigned NReq   = 4,
  parameter int unsigned FNbits = 16
) (
  input  logic                        clk_i,
  input  logic                        rstb_ni,
  input  logic [NReq-1:0]             req_i,
  input  logic [NReq-1:0][FNbits-1:0] a_i,
  input  logic [NReq-1:0][FNbits-1:0] b_i,
  output logic [NReq-1:0]             ack_o,
  output logic [FNbits-1:0]           result_o,
  output logic                        busy_o,
  output logic [$clog2(NReq)-1:0]     grant_id_o,
  output logic                        mul_en_o,
  output logic [FNbits-1:0]           mul_a_o,
  output logic [FNbits-1:0]           mul_b_o,
  input  logic                        mul_ready_i,
  input  logic [FNbits-1:0]           mul_c_i
);

  localparam int unsigned IdxW = $clog2(NReq);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StAck  = 2'd2
  } state_e;

  state_e              state_q;
  logic [NReq-1:0]     ack_q;
  logic [FNbits-1:0]   result_q;
  logic [FNbits-1:0]   mul_a_q;
  logic [FNbits-1:0]   mul_b_q;
  logic [IdxW-1:0]     grant_q;
  logic                mul_en_q;

  logic [IdxW-1:0]     sel;
  logic [IdxW-1:0]     cand;
  logic                found;

  // Scan starts just past the last grant so the previous winner is considered last.
  always_comb begin
    sel   = grant_q;
    cand  = grant_q;
    found = 1'b0;
    for (int unsigned i = 1; i <= NReq; i++) begin
      cand = IdxW'((32'(grant_q) + i) % NReq);
      if (!found && req_i[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstb_ni) begin
    if (!rstb_ni) begin
      state_q  <= StIdle;
      ack_q    <= '0;
      result_q <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      mul_en_q <= 1'b0;
      grant_q  <= IdxW'(NReq - 1);
    end else begin
      ack_q <= '0;
      case (state_q)
        StIdle: begin
          if (found && mul_ready_i) begin
            grant_q  <= sel;
            mul_a_q  <= a_i[sel];
            mul_b_q  <= b_i[sel];
            mul_en_q <= 1'b1;
            state_q  <= StWait;
          end
        end
        StWait: begin
          // Ready is stale in the start cycle; only trust it once en has dropped.
          if (mul_en_q) begin
            mul_en_q <= 1'b0;
          end else if (mul_ready_i) begin
            result_q       <= mul_c_i;
            ack_q[grant_q] <= 1'b1;
            state_q        <= StAck;
          end
        end
        StAck: begin
          state_q <= StIdle;
        end
        default: begin
          state_q  <= StIdle;
          mul_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign ack_o      = ack_q;
  assign result_o   = result_q;
  assign busy_o     = (state_q != StIdle);
  assign grant_id_o = grant_q;
  assign mul_en_o   = mul_en_q;
  assign mul_a_o    = mul_a_q;
  assign mul_b_o    = mul_b_q;

endmodule

// File: tb/tb_pergate_mul_arbiter.sv
// Bench for pergate_mul_arbiter: behavioural multiplier stub, transaction-level reference model,
// table-driven single operations, directed corner sequences and a randomized soak.
module tb_pergate_mul_arbiter;

  localparam int unsigned NReq = 4;
  localparam int unsigned FN   = 16;
  localparam int unsigned IdxW = $clog2(NReq);
  localparam int unsigned P    = 65521;

  logic                    clk = 1'b0;
  logic                    rstb = 1'b1;
  logic [NReq-1:0]         req;
  logic [NReq-1:0][FN-1:0] a;
  logic [NReq-1:0][FN-1:0] b;
  logic [NReq-1:0]         ack;
  logic [FN-1:0]           result;
  logic                    busy;
  logic [IdxW-1:0]         grant_id;
  logic                    mul_en;
  logic [FN-1:0]           mul_a;
  logic [FN-1:0]           mul_b;
  logic                    mul_ready;
  logic [FN-1:0]           mul_c;

  always #5 clk = ~clk;

  pergate_mul_arbiter #(
    .NReq  (NReq),
    .FNbits(FN)
  ) dut (
    .clk_i      (clk),
    .rstb_ni    (rstb),
    .req_i      (req),
    .a_i        (a),
    .b_i        (b),
    .ack_o      (ack),
    .result_o   (result),
    .busy_o     (busy),
    .grant_id_o (grant_id),
    .mul_en_o   (mul_en),
    .mul_a_o    (mul_a),
    .mul_b_o    (mul_b),
    .mul_ready_i(mul_ready),
    .mul_c_i    (mul_c)
  );

  function automatic int unsigned mulmod(input int unsigned x, input int unsigned y);
    return (x * y) % P;
  endfunction

  // Multiplier stub: ready comes back L cycles after the start cycle.
  int unsigned   mul_lat = 3;
  int unsigned   lat_cnt;
  logic [FN-1:0] prod;
  logic          hold_low = 1'b0;

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      lat_cnt <= 0;
      prod    <= '0;
    end else if (mul_en) begin
      lat_cnt <= mul_lat - 1;
      prod    <= FN'(mulmod(32'(mul_a), 32'(mul_b)));
    end else if (lat_cnt != 0) begin
      lat_cnt <= lat_cnt - 1;
    end
  end

  assign mul_ready = (lat_cnt == 0) && !hold_low;
  assign mul_c     = mul_ready ? prod : 16'hdead;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int unsigned ptr, input logic [NReq-1:0] r);
    for (int k = 1; k <= int'(NReq); k++) begin
      int c;
      c = (int'(ptr) + k) % int'(NReq);
      if (r[c]) return c;
    end
    return -1;
  endfunction

  // Staged requester inputs, applied one cycle at a time by step().
  logic [NReq-1:0]         stg_req = '0;
  logic [NReq-1:0][FN-1:0] stg_a = '0;
  logic [NReq-1:0][FN-1:0] stg_b = '0;
  logic                    stg_hold = 1'b0;
  bit                      auto_drop = 1'b1;

  // Reference model state.
  int              m_phase;
  int unsigned     m_ptr;
  logic [NReq-1:0] exp_ack;
  logic            exp_mul_en;
  logic            exp_busy;
  logic [IdxW-1:0] exp_grant;
  logic [FN-1:0]   exp_result;
  logic [FN-1:0]   exp_mul_a;
  logic [FN-1:0]   exp_mul_b;
  int              waits[NReq];
  int              grants = 0;
  int              cyc = 0;
  int              mul_en_seen = 0;
  int              ack_idx_q[$];
  int              ack_cyc_q[$];
  logic [FN-1:0]   ack_res_q[$];

  task automatic model_reset();
    m_phase    = 0;
    m_ptr      = NReq - 1;
    exp_ack    = '0;
    exp_mul_en = 1'b0;
    exp_busy   = 1'b0;
    exp_grant  = IdxW'(NReq - 1);
    exp_result = '0;
    exp_mul_a  = '0;
    exp_mul_b  = '0;
    for (int i = 0; i < int'(NReq); i++) waits[i] = 0;
  endtask

  // Predict outputs after the coming edge from the inputs currently applied.
  task automatic predict();
    int pick;
    case (m_phase)
      0: begin
        exp_ack = '0;
        if (|req && mul_ready) begin
          pick = rr_pick(m_ptr, req);
          for (int i = 0; i < int'(NReq); i++) begin
            if (i == pick) waits[i] = 0;
            else if (req[i]) waits[i]++;
            else waits[i] = 0;
            check("fair_wait", 32'(waits[i] <= int'(NReq) - 1), 32'd1);
          end
          m_ptr      = pick;
          exp_grant  = IdxW'(pick);
          exp_mul_a  = a[pick];
          exp_mul_b  = b[pick];
          exp_mul_en = 1'b1;
          exp_busy   = 1'b1;
          m_phase    = 1;
          grants++;
        end else begin
          exp_mul_en = 1'b0;
        end
      end
      1: begin
        exp_mul_en = 1'b0;
        m_phase    = 2;
      end
      2: begin
        if (mul_ready) begin
          exp_ack        = '0;
          exp_ack[m_ptr] = 1'b1;
          exp_result     = FN'(mulmod(32'(exp_mul_a), 32'(exp_mul_b)));
          m_phase        = 3;
        end
      end
      default: begin
        exp_ack  = '0;
        exp_busy = 1'b0;
        m_phase  = 0;
      end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    check("ack", 32'(ack), 32'(exp_ack));
    check("mul_en", 32'(mul_en), 32'(exp_mul_en));
    check("busy", 32'(busy), 32'(exp_busy));
    check("grant_id", 32'(grant_id), 32'(exp_grant));
    check("result", 32'(result), 32'(exp_result));
    if (exp_busy) begin
      check("mul_a", 32'(mul_a), 32'(exp_mul_a));
      check("mul_b", 32'(mul_b), 32'(exp_mul_b));
    end
    if (mul_en) mul_en_seen++;
    for (int k = 0; k < int'(NReq); k++) begin
      if (ack[k]) begin
        ack_idx_q.push_back(k);
        ack_cyc_q.push_back(cyc);
        ack_res_q.push_back(result);
        if (auto_drop) stg_req[k] = 1'b0;
      end
    end
    req      = stg_req;
    a        = stg_a;
    b        = stg_b;
    hold_low = stg_hold;
    #1;
    predict();
  endtask

  task automatic do_reset();
    #2;
    rstb = 1'b0;
    #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_mul_en", 32'(mul_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant_id), NReq - 1);
    check("rst_result", 32'(result), 32'd0);
    check("rst_mul_a", 32'(mul_a), 32'd0);
    check("rst_mul_b", 32'(mul_b), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rstb     = 1'b1;
    req      = stg_req;
    a        = stg_a;
    b        = stg_b;
    hold_low = stg_hold;
    #1;
    predict();
  endtask

  task automatic clear_log();
    ack_idx_q.delete();
    ack_cyc_q.delete();
    ack_res_q.delete();
  endtask

  task automatic wait_acks(input int n, input int budget);
    int used;
    used = 0;
    while (ack_idx_q.size() < n && used < budget) begin
      step();
      used++;
    end
    if (ack_idx_q.size() < n) check("ack_timeout", 32'(ack_idx_q.size()), 32'(n));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  typedef struct {
    logic [NReq-1:0] req;
    logic [FN-1:0]   a;
    logic [FN-1:0]   b;
    int unsigned     lat;
    int              grant;
    logic [FN-1:0]   res;
    int              dly;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    req = '0;
    a   = '0;
    b   = '0;

    // Pointer carries over between rows, so rows 5 and 6 exercise wrap-around choice.
    tbl[0] = '{4'b0100, 16'd3, 16'd5, 3, 2, 16'd15, 5};
    tbl[1] = '{4'b0001, 16'd7, 16'd9, 1, 0, 16'd63, 3};
    tbl[2] = '{4'b1000, 16'd300, 16'd300, 2, 3, 16'd24479, 4};
    tbl[3] = '{4'b0010, 16'hffff, 16'd2, 4, 1, 16'd28, 6};
    tbl[4] = '{4'b0011, 16'd100, 16'd200, 1, 0, 16'd20000, 3};
    tbl[5] = '{4'b1001, 16'd11, 16'd13, 2, 3, 16'd143, 4};

    do_reset();
    idle(2);

    foreach (tbl[v]) begin
      clear_log();
      mul_lat = tbl[v].lat;
      stg_req = tbl[v].req;
      for (int i = 0; i < int'(NReq); i++) begin
        stg_a[i] = tbl[v].a;
        stg_b[i] = tbl[v].b;
      end
      step();
      t0 = cyc;
      wait_acks(1, 20);
      if (ack_idx_q.size() >= 1) begin
        check("tbl_grant", 32'(ack_idx_q[0]), 32'(tbl[v].grant));
        check("tbl_delay", 32'(ack_cyc_q[0] - t0), 32'(tbl[v].dly));
        check("tbl_result", 32'(result), 32'(tbl[v].res));
        check("tbl_grant_id", 32'(grant_id), 32'(tbl[v].grant));
      end
      stg_req = '0;
      idle(3);
    end

    // All four requesting out of reset: served 0..3, spaced L+3 apart.
    clear_log();
    mul_lat = 3;
    stg_req = '1;
    for (int i = 0; i < int'(NReq); i++) begin
      stg_a[i] = FN'(i + 2);
      stg_b[i] = FN'(i + 10);
    end
    do_reset();
    wait_acks(4, 60);
    if (ack_idx_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check("all_order", 32'(ack_idx_q[i]), 32'(i));
        check("all_result", 32'(ack_res_q[i]), 32'((i + 2) * (i + 10)));
        if (i > 0) check("all_spacing", 32'(ack_cyc_q[i] - ack_cyc_q[i-1]), 32'd6);
      end
    end
    idle(3);

    // Requester 1 keeps requesting while 3 waits: 3 must be served in between.
    clear_log();
    auto_drop = 1'b0;
    stg_req   = 4'b0010;
    idle(3);
    stg_req[3] = 1'b1;
    for (int n = 0; n < 60 && ack_idx_q.size() < 3; n++) begin
      step();
      if (ack_idx_q.size() >= 2) auto_drop = 1'b1;
    end
    auto_drop = 1'b1;
    check("rr_count", 32'(ack_idx_q.size()), 32'd3);
    if (ack_idx_q.size() >= 3) begin
      check("rr_first", 32'(ack_idx_q[0]), 32'd1);
      check("rr_second", 32'(ack_idx_q[1]), 32'd3);
      check("rr_third", 32'(ack_idx_q[2]), 32'd1);
    end
    stg_req = '0;
    idle(15);

    // Multiplier not ready at idle: no start until ready returns.
    clear_log();
    mul_lat     = 2;
    mul_en_seen = 0;
    stg_hold    = 1'b1;
    stg_req     = 4'b0001;
    stg_a[0]    = 16'd12;
    stg_b[0]    = 16'd12;
    idle(5);
    check("hold_no_en", 32'(mul_en_seen), 32'd0);
    check("hold_busy", 32'(busy), 32'd0);
    stg_hold = 1'b0;
    step();
    step();
    check("hold_release_en", 32'(mul_en), 32'd1);
    wait_acks(1, 20);
    check("hold_result", 32'(result), 32'd144);
    idle(3);

    // Operand change after grant must not reach the multiplier.
    clear_log();
    mul_lat  = 3;
    stg_a[0] = 16'd7;
    stg_b[0] = 16'd6;
    stg_req  = 4'b0001;
    step();
    step();
    stg_a[0] = 16'd9;
    step();
    check("capture_mul_a", 32'(mul_a), 32'd7);
    wait_acks(1, 20);
    check("capture_result", 32'(result), 32'd42);
    idle(3);

    // Reset while waiting on the multiplier, then a clean operation.
    clear_log();
    mul_lat  = 4;
    stg_a[0] = 16'd5;
    stg_b[0] = 16'd5;
    stg_req  = 4'b0001;
    step();
    step();
    step();
    stg_a[0] = 16'd4;
    stg_b[0] = 16'd8;
    clear_log();
    do_reset();
    t0 = cyc;
    wait_acks(1, 20);
    if (ack_idx_q.size() >= 1) begin
      check("post_rst_grant", 32'(ack_idx_q[0]), 32'd0);
      check("post_rst_delay", 32'(ack_cyc_q[0] - t0), 32'd6);
      check("post_rst_result", 32'(result), 32'd32);
    end
    idle(3);

    // Random soak against the model.
    grants = 0;
    for (int n = 0; n < 700; n++) begin
      mul_lat  = $urandom_range(1, 4);
      stg_hold = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < int'(NReq); i++) begin
        if (!stg_req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            stg_req[i] = 1'b1;
            stg_a[i]   = FN'($urandom);
            stg_b[i]   = FN'($urandom);
          end
        end else if (m_phase != 0 && int'(exp_grant) == i) begin
          if ($urandom_range(0, 3) == 0) stg_a[i] = FN'($urandom);
          if ($urandom_range(0, 15) == 0) stg_req[i] = 1'b0;
        end
      end
      step();
    end
    stg_req  = '0;
    stg_hold = 1'b0;
    idle(20);
    check("rand_ops", 32'(grants > 50), 32'd1);
    check("rand_drained", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
